row_accumulator: RTL and testbench

ROW_ACCUMULATOR -- requirements
Module: row_accumulator

---
 rtl/row_accumulator_pkg.sv | 17 +
 rtl/xvec_ram.sv | 20 ++
 rtl/row_accumulator.sv | 148 ++++++++++++++
 tb/tb_row_accumulator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_accumulator_pkg.sv
// Shared widths and FSM encoding for the sparse-row multiply-accumulate block.
package row_accumulator_pkg;

  localparam int VAL_W   = 48;
  localparam int ADDR_W  = 11;
  localparam int ACC_W   = 101;
  localparam int PROD_W  = 2 * VAL_W;
  localparam int X_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/xvec_ram.sv
// Vector-x storage: one write port, one synchronous read port, contents survive reset.
module xvec_ram
  import row_accumulator_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [VAL_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [VAL_W-1:0]  rd_data
);

  logic [VAL_W-1:0] mem [X_DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/row_accumulator.sv
// Accumulates A(i,j)*x(j) per row from a flagged element stream and emits one result per row.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no row open; x writes allowed; waiting for a flagged element
// ST_ACCUM | row(s) streaming in, one element per cycle
// ST_FLUSH | EOF seen; draining pipeline, then emitting the open row
// ST_DONE  | final row emitted; pulse done and return to idle
module row_accumulator
  import row_accumulator_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [VAL_W-1:0]  Diagonal,
  input  logic [VAL_W:0]    Element,
  input  logic [ADDR_W-1:0] ElementAddr,
  input  logic              EOF,
  input  logic              xwr_en,
  input  logic [ADDR_W-1:0] xwr_addr,
  input  logic [VAL_W-1:0]  xwr_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  row_sum,
  output logic [VAL_W-1:0]  row_diag,
  output logic [ADDR_W-1:0] row_index,
  output logic              busy,
  output logic              done
);

  state_t state;

  logic              new_row;
  logic              accept;
  logic [VAL_W-1:0]  x_rd;

  logic              s1_valid;
  logic              s1_flag;
  logic [VAL_W-1:0]  s1_val;
  logic [VAL_W-1:0]  s1_diag;

  logic              s2_valid;
  logic              s2_flag;
  logic [PROD_W-1:0] s2_prod;
  logic [VAL_W-1:0]  s2_diag;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  prod_ext;
  logic [VAL_W-1:0]  open_diag;
  logic              row_open;
  logic [ADDR_W-1:0] emit_count;
  logic              drain;
  logic              emit_row;

  assign new_row = Element[VAL_W];
  assign accept  = in_valid && (((state == ST_IDLE) && new_row) || (state == ST_ACCUM));
  assign busy    = (state == ST_ACCUM) || (state == ST_FLUSH);

  xvec_ram u_xvec_ram (
    .clock   (clock),
    .wr_en   (xwr_en && (state == ST_IDLE)),
    .wr_addr (xwr_addr),
    .wr_data (xwr_data),
    .rd_addr (ElementAddr),
    .rd_data (x_rd)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    s1_flag <= new_row;
    s1_val  <= Element[VAL_W-1:0];
    s1_diag <= Diagonal;
    s2_flag <= s1_flag;
    s2_diag <= s1_diag;
    s2_prod <= $signed({{VAL_W{s1_val[VAL_W-1]}}, s1_val})
             * $signed({{VAL_W{x_rd[VAL_W-1]}}, x_rd});
  end

  assign prod_ext = {{(ACC_W-PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
  assign drain    = (state == ST_FLUSH) && !s1_valid && !s2_valid;
  assign emit_row = row_open && ((s2_valid && s2_flag) || drain);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      open_diag  <= '0;
      row_open   <= 1'b0;
      emit_count <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      row_sum    <= '0;
      row_diag   <= '0;
      row_index  <= '0;
    end else begin
      out_valid <= emit_row;
      done      <= 1'b0;

      // The closing row is complete before the next flagged product lands.
      if (emit_row) begin
        row_sum    <= acc;
        row_diag   <= open_diag;
        row_index  <= emit_count;
        emit_count <= emit_count + ADDR_W'(1);
      end

      if (s2_valid) begin
        if (s2_flag) begin
          acc       <= prod_ext;
          open_diag <= s2_diag;
          row_open  <= 1'b1;
        end else begin
          acc <= acc + prod_ext;
        end
      end

      case (state)
        ST_IDLE: begin
          if (accept) state <= EOF ? ST_FLUSH : ST_ACCUM;
        end
        ST_ACCUM: begin
          if (EOF) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (drain) begin
            row_open <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_accumulator.sv
// Randomized scoreboard bench for row_accumulator against a plain-arithmetic row model.
module tb_row_accumulator;

  localparam int VW = 48;
  localparam int AW = 11;
  localparam int CW = 101;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] Diagonal = '0;
  logic [VW:0]   Element = '0;
  logic [AW-1:0] ElementAddr = '0;
  logic          EOF = 1'b0;
  logic          xwr_en = 1'b0;
  logic [AW-1:0] xwr_addr = '0;
  logic [VW-1:0] xwr_data = '0;
  logic          out_valid;
  logic [CW-1:0] row_sum;
  logic [VW-1:0] row_diag;
  logic [AW-1:0] row_index;
  logic          busy;
  logic          done;

  row_accumulator dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .Diagonal    (Diagonal),
    .Element     (Element),
    .ElementAddr (ElementAddr),
    .EOF         (EOF),
    .xwr_en      (xwr_en),
    .xwr_addr    (xwr_addr),
    .xwr_data    (xwr_data),
    .out_valid   (out_valid),
    .row_sum     (row_sum),
    .row_diag    (row_diag),
    .row_index   (row_index),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CW-1:0] sum;
    logic [VW-1:0] diag;
    logic [AW-1:0] idx;
    int            cyc;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  bit            done_pending = 0;
  bit            done_seen = 0;

  logic [VW-1:0] xm [0:2047];
  bit            m_open = 0;
  logic [CW-1:0] m_sum = '0;
  logic [VW-1:0] m_diag = '0;
  logic [AW-1:0] m_idx = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [CW-1:0] prod(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic signed [CW-1:0] ea, eb;
    ea = {{(CW-VW){a[VW-1]}}, a};
    eb = {{(CW-VW){b[VW-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [VW-1:0] rnd48();
    logic [31:0] a, b;
    a = $urandom();
    b = $urandom();
    return {a[15:0], b};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_row(input int c, input bit last);
    exp_t e;
    e.sum = m_sum; e.diag = m_diag; e.idx = m_idx; e.cyc = c; e.last = last;
    exp_q.push_back(e);
    m_idx++;
  endtask

  task automatic clear_inputs();
    in_valid = 0; EOF = 0; xwr_en = 0; Element = '0; ElementAddr = '0; Diagonal = '0;
  endtask

  // One input cycle; the model applies the row rules to whatever the DUT should accept.
  task automatic drive(input bit iv, input bit flag, input logic [VW-1:0] val,
                       input logic [AW-1:0] addr, input logic [VW-1:0] diag, input bit eof);
    logic [CW-1:0] p;
    @(posedge clock); #1;
    in_valid = iv; Element = {flag, val}; ElementAddr = addr; Diagonal = diag;
    EOF = eof; xwr_en = 0;
    if (iv && (m_open || flag)) begin
      p = prod(val, xm[addr]);
      if (flag) begin
        if (m_open) push_row(cyc + 3, 1'b0);
        m_sum = p; m_diag = diag; m_open = 1;
      end else begin
        m_sum = m_sum + p;
      end
    end
    if (eof && m_open) begin
      push_row(-1, 1'b1);
      m_open = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      clear_inputs();
    end
  endtask

  task automatic xwrite(input logic [AW-1:0] addr, input logic [VW-1:0] data);
    @(posedge clock); #1;
    clear_inputs();
    xwr_en = 1; xwr_addr = addr; xwr_data = data;
    if (!m_open) xm[addr] = data;
  endtask

  task automatic wait_done();
    @(posedge clock); #1;
    clear_inputs();
    done_seen = 0;
    for (int i = 0; i < 64 && !done_seen; i++) @(posedge clock);
    n_cmp++;
    if (!done_seen) begin
      n_bad++;
      $display("FAIL flush_timeout: actual=no_done required=done_within_64");
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 0;
    clear_inputs();
    exp_q.delete();
    m_open = 0; m_idx = '0; done_pending = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row_sum", row_sum, 0);
    check("rst_row_diag", row_diag, 0);
    check("rst_row_index", row_index, 0);
    @(posedge clock); #1;
    reset = 1;
  endtask

  always @(negedge clock) begin
    if (done_pending) begin
      check("done_pulse", done, 1);
      check("busy_after_done", busy, 0);
      done_pending = 0;
    end else if (done && reset) begin
      n_cmp++; n_bad++;
      $display("FAIL spurious_done: actual=1 required=0");
    end
    if (done) done_seen = 1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out_valid: actual=row_sum %0h index %0d required=none", row_sum, row_index);
      end else begin
        mon_e = exp_q.pop_front();
        check("row_sum", row_sum, mon_e.sum);
        check("row_diag", row_diag, mon_e.diag);
        check("row_index", row_index, mon_e.idx);
        if (mon_e.cyc >= 0) check("emit_latency", cyc, mon_e.cyc);
        if (mon_e.last) done_pending = 1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] addrs [6];
    int            rows, nel;
    bit            eof_on_elem;

    do_reset();

    // Worked example: 4*2 + 1*5 = 13, then a zero-valued padding row closes out.
    xwrite(3, 2);
    xwrite(7, 5);
    drive(1, 1, 4, 3, 10, 0);
    drive(1, 0, 1, 7, rnd48(), 0);
    @(negedge clock);
    check("busy_in_accum", busy, 1);
    drive(1, 1, 0, 0, 20, 1);
    wait_done();

    // Four single-element rows back to back.
    do_reset();
    xwrite(0, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, rnd48(), 0);
    drive(0, 0, 0, 0, 0, 1);
    wait_done();

    // Negative element.
    xwrite(1, 4);
    drive(1, 1, -48'sd3, 1, 48'd77, 1);
    wait_done();

    // A write during ACCUM must not land.
    xwrite(5, 7);
    drive(1, 1, 1, 5, 48'd3, 0);
    xwrite(5, 99);
    drive(1, 0, 1, 5, 0, 1);
    wait_done();
    drive(1, 1, 1, 5, 48'd4, 1);
    wait_done();

    // Reset with two elements in flight; the pending row must vanish, x must survive.
    drive(1, 1, 4, 3, 10, 0);
    drive(1, 0, 1, 7, 0, 0);
    drive(1, 1, 1, 3, 11, 0);
    drive(1, 0, 1, 7, 0, 0);
    do_reset();
    drive(1, 1, 4, 3, 10, 0);
    drive(1, 0, 1, 7, 0, 1);
    wait_done();

    // Randomized matrices.
    for (int m = 0; m < 8; m++) begin
      for (int a = 0; a < 6; a++) begin
        addrs[a] = AW'($urandom_range(0, 2047));
        xwrite(addrs[a], rnd48());
      end
      if ($urandom_range(0, 2) == 0) drive(1, 0, rnd48(), addrs[0], rnd48(), 0);
      rows = $urandom_range(1, 5);
      eof_on_elem = $urandom_range(0, 1) == 1;
      for (int r = 0; r < rows; r++) begin
        nel = $urandom_range(1, 4);
        for (int e = 0; e < nel; e++) begin
          drive(1, e == 0, rnd48(), addrs[$urandom_range(0, 5)], rnd48(),
                eof_on_elem && (r == rows - 1) && (e == nel - 1));
          if ($urandom_range(0, 3) == 0 && !(eof_on_elem && r == rows - 1 && e == nel - 1))
            idle(1);
        end
      end
      if (!eof_on_elem) drive(0, 0, 0, 0, 0, 1);
      wait_done();
    end

    // Long run of single-element rows so row_index wraps 2047 -> 0.
    do_reset();
    xwrite(9, rnd48());
    for (int i = 0; i < 2049; i++) drive(1, 1, rnd48(), 9, rnd48(), i == 2048);
    wait_done();

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
